sic_detector: RTL

Successive-interference-cancellation back-substitution stage, directly downstream of the QR/row-rotation array in the 4x4 MIMO detector. It captures the upper-triangular R matrix and the rotated receive vector z = Q^H·y, then detects the four transmitted symbols from layer 3 down to layer 0. It uses one complex shift-add MAC and a per-dimension slicer and needs no multipliers or dividers.

---
 rtl/mimo_pkg.sv | 53 +++++
 rtl/sic_detector_if.sv | 31 +++
 rtl/sic_slicer.sv | 31 +++
 rtl/sic_detector.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mimo_pkg.sv
// Shared definitions for the 4x4 MIMO detector back-substitution stage.
//   WL     : word length of every R and z component (signed two's complement)
//   NT     : number of layers (fixed schedule assumes 4)
//   ACC_W  : accumulator width for the interference-cancellation MAC
//   LVL_*  : 2-bit per-dimension level codes (00=-3, 01=-1, 10=+1, 11=+3)
//   state_t: SIC FSM state encoding
// Build option: QAM16_EN selects the 16-QAM (+-1/+-3) datapath; undefined
// gives the QPSK-only (+-1) datapath.
package mimo_pkg;

  localparam int WL    = 16;
  localparam int NT    = 4;
  localparam int ACC_W = WL + 4;

  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b10;
  localparam logic [1:0] LVL_P3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLICE = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [WL-1:0] v);
    return {{(ACC_W-WL){v[WL-1]}}, v};
  endfunction

  // Multiply a component by a detected level without a multiplier:
  // x3 is built as (v<<1)+v and the sign comes from a negate.
  function automatic logic signed [ACC_W-1:0] lvl_mul(input logic signed [WL-1:0] v,
                                                     input logic [1:0] lvl);
    logic signed [ACC_W-1:0] ext;
    ext = sext(v);
`ifdef QAM16_EN
    begin
      logic signed [ACC_W-1:0] x3;
      x3 = (ext <<< 1) + ext;
      case (lvl)
        LVL_M3:  return -x3;
        LVL_M1:  return -ext;
        LVL_P1:  return ext;
        default: return x3;
      endcase
    end
`else
    return (lvl >= LVL_P1) ? ext : -ext;
`endif
  endfunction

endpackage

// File: rtl/sic_detector_if.sv
// Handshake/data bundle of the SIC detector.
//   In_valid/In_ready   : R/z input handshake
//   R_x/R_y             : R matrix, entry (i,j) at [(4i+j)*WL +: WL]
//   Z_x/Z_y             : rotated receive vector, entry i at [i*WL +: WL]
//   Sym_x/Sym_y         : detected level codes, layer i at [2i +: 2]
//   Out_valid/Out_ready : result handshake
// modport master drives the inputs (upstream/bench), slave is the detector.
interface sic_detector_if;
  import mimo_pkg::*;

  logic              In_valid;
  logic              In_ready;
  logic [WL*16-1:0]  R_x;
  logic [WL*16-1:0]  R_y;
  logic [WL*4-1:0]   Z_x;
  logic [WL*4-1:0]   Z_y;
  logic [7:0]        Sym_x;
  logic [7:0]        Sym_y;
  logic              Out_valid;
  logic              Out_ready;

  modport master (
    output In_valid, R_x, R_y, Z_x, Z_y, Out_ready,
    input  In_ready, Sym_x, Sym_y, Out_valid
  );

  modport slave (
    input  In_valid, R_x, R_y, Z_x, Z_y, Out_ready,
    output In_ready, Sym_x, Sym_y, Out_valid
  );
endinterface

// File: rtl/sic_slicer.sv
// Combinational single-dimension slicer.
//   r   : accumulator value for one dimension (ACC_W, signed)
//   d   : diagonal entry R_ii (real positive)
//   lvl : 2-bit level code
// QAM16_EN defined: four-level decision with thresholds 0 and +-2d, ties up.
// QAM16_EN undefined: sign-only decision, d is not needed.
module sic_slicer
  import mimo_pkg::*;
(
  input  logic signed [ACC_W-1:0] r,
  input  logic signed [WL-1:0]    d,
  output logic [1:0]              lvl
);

`ifdef QAM16_EN
  logic signed [ACC_W-1:0] d2;
  assign d2 = sext(d) <<< 1;

  always_comb begin
    lvl = LVL_M3;
    if (r >= d2)          lvl = LVL_P3;
    else if (!r[ACC_W-1]) lvl = LVL_P1;
    else if (r >= -d2)    lvl = LVL_M1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{d, r[ACC_W-2:0]};
  assign lvl = r[ACC_W-1] ? LVL_M1 : LVL_P1;
`endif

endmodule

// File: rtl/sic_detector.sv
// SIC back-substitution: captures R and z, then detects layers 3..0 with a
// single complex shift-add MAC and two slicers (x and y).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sic_detector_if.slave (input R/z handshake, output symbol handshake)
// Schedule per set: SLICE3, MAC2(3), SLICE2, MAC1(2..3), SLICE1, MAC0(1..3),
// SLICE0, then DONE until Out_ready. Accept-to-Out_valid latency is 10 clocks.
// Build option: QAM16_EN (16-QAM); undefined builds the QPSK-only datapath.
module sic_detector
  import mimo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sic_detector_if.slave bus
);

  state_t                  state_reg, state_next;
  logic [1:0]              layer_reg, layer_next;
  logic [1:0]              col_reg, col_next;
  logic [WL*16-1:0]        rx_reg, ry_reg;
  logic [WL*4-1:0]         zx_reg, zy_reg;
  logic signed [ACC_W-1:0] acc_x_reg, acc_y_reg;
  logic [7:0]              sym_x_reg, sym_y_reg;
  logic                    in_ready_reg, out_valid_reg;

  logic accept;
  assign accept = bus.In_valid && in_ready_reg;

  // Operand selection: {i,j} is exactly the flat index 4i+j.
  logic [3:0]              rij_idx, rii_idx;
  logic [1:0]              layer_m1;
  logic signed [WL-1:0]    rij_x, rij_y, rii;
  logic [1:0]              sj_x, sj_y;
  logic signed [ACC_W-1:0] term_re, term_im;
  logic [1:0]              lvl_x, lvl_y;

  assign rij_idx  = {layer_reg, col_reg};
  assign rii_idx  = {layer_reg, layer_reg};
  assign layer_m1 = layer_reg - 2'd1;
  assign rij_x    = rx_reg[rij_idx*WL +: WL];
  assign rij_y    = ry_reg[rij_idx*WL +: WL];
  assign rii      = rx_reg[rii_idx*WL +: WL];
  assign sj_x     = sym_x_reg[{col_reg, 1'b0} +: 2];
  assign sj_y     = sym_y_reg[{col_reg, 1'b0} +: 2];

  // (Rx + jRy)(sx + jsy)
  assign term_re = lvl_mul(rij_x, sj_x) - lvl_mul(rij_y, sj_y);
  assign term_im = lvl_mul(rij_x, sj_y) + lvl_mul(rij_y, sj_x);

  sic_slicer u_slicer_x (.r(acc_x_reg), .d(rii), .lvl(lvl_x));
  sic_slicer u_slicer_y (.r(acc_y_reg), .d(rii), .lvl(lvl_y));

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    col_next   = col_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SLICE;
          layer_next = 2'd3;
        end
      end
      ST_SLICE: begin
        if (layer_reg == 2'd0) begin
          state_next = ST_DONE;
        end else begin
          // Next layer starts its MAC at column i+1, which is the old layer.
          state_next = ST_MAC;
          layer_next = layer_m1;
          col_next   = layer_reg;
        end
      end
      ST_MAC: begin
        if (col_reg == 2'd3) state_next = ST_SLICE;
        else                 col_next   = col_reg + 2'd1;
      end
      ST_DONE: begin
        if (bus.Out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      layer_reg     <= '0;
      col_reg       <= '0;
      rx_reg        <= '0;
      ry_reg        <= '0;
      zx_reg        <= '0;
      zy_reg        <= '0;
      acc_x_reg     <= '0;
      acc_y_reg     <= '0;
      sym_x_reg     <= '0;
      sym_y_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      layer_reg     <= layer_next;
      col_reg       <= col_next;
      in_ready_reg  <= (state_next == ST_IDLE);
      out_valid_reg <= (state_next == ST_DONE);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rx_reg    <= bus.R_x;
            ry_reg    <= bus.R_y;
            zx_reg    <= bus.Z_x;
            zy_reg    <= bus.Z_y;
            acc_x_reg <= sext(bus.Z_x[3*WL +: WL]);
            acc_y_reg <= sext(bus.Z_y[3*WL +: WL]);
          end
        end
        ST_SLICE: begin
          sym_x_reg[{layer_reg, 1'b0} +: 2] <= lvl_x;
          sym_y_reg[{layer_reg, 1'b0} +: 2] <= lvl_y;
          if (layer_reg != 2'd0) begin
            acc_x_reg <= sext(zx_reg[layer_m1*WL +: WL]);
            acc_y_reg <= sext(zy_reg[layer_m1*WL +: WL]);
          end
        end
        ST_MAC: begin
          acc_x_reg <= acc_x_reg - term_re;
          acc_y_reg <= acc_y_reg - term_im;
        end
        default: ;
      endcase
    end
  end

  assign bus.In_ready  = in_ready_reg;
  assign bus.Out_valid = out_valid_reg;
  assign bus.Sym_x     = sym_x_reg;
  assign bus.Sym_y     = sym_y_reg;

endmodule
